// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared field widths, field bit positions, bubble constants and
//            control bundle typedefs for the control pipeline registers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int CTRL_WB_W  = 2;
  localparam int CTRL_M_W   = 3;
  localparam int CTRL_EX_W  = 8;
  localparam int CTRL_REG_W = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef logic [CTRL_WB_W-1:0]  wb_t;
  typedef logic [CTRL_M_W-1:0]   m_t;
  typedef logic [CTRL_EX_W-1:0]  ex_t;
  typedef logic [CTRL_REG_W-1:0] reg_t;

  localparam wb_t  WB_BUBBLE  = '0;
  localparam m_t   M_BUBBLE   = '0;
  localparam ex_t  EX_BUBBLE  = '0;
  localparam reg_t REG_BUBBLE = '0;

  function automatic logic is_load(input m_t m);
    return m[M_MEMREAD];
  endfunction

endpackage : ctrl_pkg

`default_nettype wire

// File: rtl/ctrl_pipe_regs_if.sv
// ============================================================================
// ctrl_pipe_regs_if : decode-side inputs, per-stage control outputs and the
//                     stall indication of the control pipeline registers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ctrl_pipe_regs_if
  import ctrl_pkg::*;
#(
  parameter int WB_W  = CTRL_WB_W,
  parameter int M_W   = CTRL_M_W,
  parameter int EX_W  = CTRL_EX_W,
  parameter int REG_W = CTRL_REG_W
) ();

  logic             id_valid;
  logic [WB_W-1:0]  id_wb;
  logic [M_W-1:0]   id_m;
  logic [EX_W-1:0]  id_ex;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_dst;
  logic             flush;

  logic             ex_valid;
  logic [WB_W-1:0]  ex_wb;
  logic [M_W-1:0]   ex_m;
  logic [EX_W-1:0]  ex_ex;
  logic [REG_W-1:0] ex_dst;

  logic             mem_valid;
  logic [WB_W-1:0]  mem_wb;
  logic [M_W-1:0]   mem_m;
  logic [REG_W-1:0] mem_dst;

  logic             wb_valid;
  logic [WB_W-1:0]  wb_wb;
  logic [REG_W-1:0] wb_dst;

  logic             stall_out;

  modport master (
    output id_valid, id_wb, id_m, id_ex, id_rs, id_rt, id_dst, flush,
    input  ex_valid, ex_wb, ex_m, ex_ex, ex_dst,
    input  mem_valid, mem_wb, mem_m, mem_dst,
    input  wb_valid, wb_wb, wb_dst,
    input  stall_out
  );

  modport slave (
    input  id_valid, id_wb, id_m, id_ex, id_rs, id_rt, id_dst, flush,
    output ex_valid, ex_wb, ex_m, ex_ex, ex_dst,
    output mem_valid, mem_wb, mem_m, mem_dst,
    output wb_valid, wb_wb, wb_dst,
    output stall_out
  );

endinterface : ctrl_pipe_regs_if

`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
// ============================================================================
// ctrl_stage_reg : one pipeline stage register with async active-low reset,
//                  load enable and clear-to-bubble (clear wins over load).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic         clear,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : ctrl_stage_reg

`default_nettype wire

// File: rtl/ctrl_pipe_regs.sv
// ============================================================================
// ctrl_pipe_regs : ID/EX, EX/MEM and MEM/WB control registers with flush and
//                  optional load-use stall (macro LOAD_USE_STALL_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_pipe_regs
  import ctrl_pkg::*;
#(
  parameter int WB_W  = CTRL_WB_W,
  parameter int M_W   = CTRL_M_W,
  parameter int EX_W  = CTRL_EX_W,
  parameter int REG_W = CTRL_REG_W
) (
  input wire logic        clk,
  input wire logic        rst_n,
  ctrl_pipe_regs_if.slave bus
);

  localparam int IDEX_W  = 1 + WB_W + M_W + EX_W + REG_W;
  localparam int EXMEM_W = 1 + WB_W + M_W + REG_W;
  localparam int MEMWB_W = 1 + WB_W + REG_W;

  logic [IDEX_W-1:0]  w_idex_d;
  logic [IDEX_W-1:0]  r_idex_q;
  logic [EXMEM_W-1:0] w_exmem_d;
  logic [EXMEM_W-1:0] r_exmem_q;
  logic [MEMWB_W-1:0] w_memwb_d;
  logic [MEMWB_W-1:0] r_memwb_q;

  logic w_hazard;
  logic w_stall;
  logic w_idex_clear;

`ifdef LOAD_USE_STALL_EN
  // A load in EX whose destination feeds the decoding instruction; r0 never hazards.
  assign w_hazard = bus.ex_valid
                  & bus.ex_m[M_MEMREAD]
                  & bus.id_valid
                  & (bus.ex_dst != '0)
                  & ((bus.ex_dst == bus.id_rs) | (bus.ex_dst == bus.id_rt));
`else
  logic unused_src_regs;
  assign unused_src_regs = ^{bus.id_rs, bus.id_rt};
  assign w_hazard        = 1'b0;
`endif

  assign w_stall       = w_hazard & ~bus.flush;
  assign bus.stall_out = w_stall;

  // ID/EX: invalid decode, stall and flush all collapse into a bubble.
  assign w_idex_clear = bus.flush | w_stall | ~bus.id_valid;
  assign w_idex_d     = {bus.id_valid, bus.id_wb, bus.id_m, bus.id_ex, bus.id_dst};

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (w_idex_clear),
    .d     (w_idex_d),
    .q     (r_idex_q)
  );

  assign {bus.ex_valid, bus.ex_wb, bus.ex_m, bus.ex_ex, bus.ex_dst} = r_idex_q;

  assign w_exmem_d = {bus.ex_valid, bus.ex_wb, bus.ex_m, bus.ex_dst};

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (bus.flush),
    .d     (w_exmem_d),
    .q     (r_exmem_q)
  );

  assign {bus.mem_valid, bus.mem_wb, bus.mem_m, bus.mem_dst} = r_exmem_q;

  // The branch resolving in MEM is older than the flush, so it still retires.
  assign w_memwb_d = {bus.mem_valid, bus.mem_wb, bus.mem_dst};

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (1'b0),
    .d     (w_memwb_d),
    .q     (r_memwb_q)
  );

  assign {bus.wb_valid, bus.wb_wb, bus.wb_dst} = r_memwb_q;

endmodule : ctrl_pipe_regs

`default_nettype wire

// File: tb/tb_ctrl_pipe_regs.sv
// ============================================================================
// tb_ctrl_pipe_regs : directed and randomized bench for ctrl_pipe_regs with an
//                     instruction-level reference model of the three stages.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_regs;
  import ctrl_pkg::*;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_regs_if bus ();

  ctrl_pipe_regs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One in-flight instruction as seen by the model.
  typedef struct packed {
    logic v;
    wb_t  wb;
    m_t   m;
    ex_t  ex;
    reg_t dst;
  } ins_t;

  localparam ins_t BUBBLE = {1'b0, WB_BUBBLE, M_BUBBLE, EX_BUBBLE, REG_BUBBLE};

  ins_t m_ex  = BUBBLE;
  ins_t m_mem = BUBBLE;
  ins_t m_wb  = BUBBLE;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    return STALL_EN && !bus.flush && bus.id_valid && m_ex.v && is_load(m_ex.m) &&
           (m_ex.dst != 0) && (m_ex.dst == bus.id_rs || m_ex.dst == bus.id_rt);
  endfunction

  task automatic check_model();
    cmp("ex_valid",  32'(bus.ex_valid),  32'(m_ex.v));
    cmp("ex_wb",     32'(bus.ex_wb),     32'(m_ex.wb));
    cmp("ex_m",      32'(bus.ex_m),      32'(m_ex.m));
    cmp("ex_ex",     32'(bus.ex_ex),     32'(m_ex.ex));
    cmp("ex_dst",    32'(bus.ex_dst),    32'(m_ex.dst));
    cmp("mem_valid", 32'(bus.mem_valid), 32'(m_mem.v));
    cmp("mem_wb",    32'(bus.mem_wb),    32'(m_mem.wb));
    cmp("mem_m",     32'(bus.mem_m),     32'(m_mem.m));
    cmp("mem_dst",   32'(bus.mem_dst),   32'(m_mem.dst));
    cmp("wb_valid",  32'(bus.wb_valid),  32'(m_wb.v));
    cmp("wb_wb",     32'(bus.wb_wb),     32'(m_wb.wb));
    cmp("wb_dst",    32'(bus.wb_dst),    32'(m_wb.dst));
    cmp("stall_out", 32'(bus.stall_out), 32'(model_stall()));
  endtask

  // Instruction-level advance: the oldest retires into WB, flush kills the two
  // youngest, and only an accepted, unstalled decode enters EX.
  task automatic model_step();
    bit st;
    st    = model_stall();
    m_wb  = m_mem;
    m_mem = bus.flush ? BUBBLE : m_ex;
    if (bus.id_valid && !bus.flush && !st)
      m_ex = {1'b1, bus.id_wb, bus.id_m, bus.id_ex, bus.id_dst};
    else
      m_ex = BUBBLE;
  endtask

  task automatic model_reset();
    m_ex  = BUBBLE;
    m_mem = BUBBLE;
    m_wb  = BUBBLE;
  endtask

  // Check, take one rising edge, advance the model, land on the falling edge.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input wb_t wb, input m_t m, input ex_t ex,
                        input reg_t rs, input reg_t rt, input reg_t dst);
    bus.id_valid = v;
    bus.id_wb    = wb;
    bus.id_m     = m;
    bus.id_ex    = ex;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_dst   = dst;
  endtask

  task automatic idle();
    set_id(1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.flush = 1'b0;
    idle();

    // Reset state
    @(negedge clk);
    #1;
    cmp("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    cmp("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    cmp("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
    cmp("rst_stall",     32'(bus.stall_out), 32'd0);
    model_reset();
    check_model();
    rst_n = 1'b1;

    // First instruction after reset release walks the pipe one stage per edge
    set_id(1'b1, 2'b10, 3'b000, 8'h82, 5'd0, 5'd0, 5'd3);
    step();
    cmp("lat1_ex_valid", 32'(bus.ex_valid), 32'd1);
    cmp("lat1_ex_wb",    32'(bus.ex_wb),    32'h2);
    cmp("lat1_ex_ex",    32'(bus.ex_ex),    32'h82);
    cmp("lat1_ex_dst",   32'(bus.ex_dst),   32'd3);
    idle();
    step();
    cmp("lat2_mem_valid", 32'(bus.mem_valid), 32'd1);
    cmp("lat2_mem_wb",    32'(bus.mem_wb),    32'h2);
    step();
    cmp("lat3_wb_valid", 32'(bus.wb_valid), 32'd1);
    cmp("lat3_wb_wb",    32'(bus.wb_wb),    32'h2);
    cmp("lat3_wb_dst",   32'(bus.wb_dst),   32'd3);
    drain(2);

    // Load-use: load r5 then a consumer of r5
    set_id(1'b1, 2'b11, 3'b010, 8'h00, 5'd0, 5'd0, 5'd5);
    step();
    set_id(1'b1, 2'b10, 3'b000, 8'h01, 5'd5, 5'd7, 5'd6);
    #1;
    cmp("lu_stall", 32'(bus.stall_out), 32'(STALL_EN));
    step();
    cmp("lu_ex_valid", 32'(bus.ex_valid), STALL_EN ? 32'd0 : 32'd1);
    cmp("lu_mem_m",    32'(bus.mem_m),    32'h2);
    cmp("lu_mem_dst",  32'(bus.mem_dst),  32'd5);
    #1;
    cmp("lu_stall_released", 32'(bus.stall_out), 32'd0);
    step();
    drain(3);

    // Load into r0 never stalls
    set_id(1'b1, 2'b11, 3'b010, 8'h00, 5'd0, 5'd0, 5'd0);
    step();
    set_id(1'b1, 2'b10, 3'b000, 8'h00, 5'd3, 5'd0, 5'd2);
    #1;
    cmp("r0_stall", 32'(bus.stall_out), 32'd0);
    step();
    drain(3);

    // Flush with a simultaneous load-use hazard
    set_id(1'b1, 2'b01, 3'b000, 8'h00, 5'd0, 5'd0, 5'd9);
    step();
    set_id(1'b1, 2'b11, 3'b010, 8'h00, 5'd0, 5'd0, 5'd4);
    step();
    set_id(1'b1, 2'b10, 3'b000, 8'h00, 5'd4, 5'd4, 5'd1);
    bus.flush = 1'b1;
    #1;
    cmp("fl_stall", 32'(bus.stall_out), 32'd0);
    step();
    bus.flush = 1'b0;
    cmp("fl_ex_valid",  32'(bus.ex_valid),  32'd0);
    cmp("fl_mem_valid", 32'(bus.mem_valid), 32'd0);
    cmp("fl_wb_valid",  32'(bus.wb_valid),  32'd1);
    cmp("fl_wb_wb",     32'(bus.wb_wb),     32'h1);
    cmp("fl_wb_dst",    32'(bus.wb_dst),    32'd9);
    drain(3);

    // Asynchronous reset between edges with all three stages occupied
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 2'b10, 3'b000, 8'(i + 1), 5'd0, 5'd0, 5'(i + 10));
      step();
    end
    idle();
    #1 rst_n = 1'b0;
    #1;
    cmp("ar_ex_valid",  32'(bus.ex_valid),  32'd0);
    cmp("ar_mem_valid", 32'(bus.mem_valid), 32'd0);
    cmp("ar_wb_valid",  32'(bus.wb_valid),  32'd0);
    cmp("ar_stall",     32'(bus.stall_out), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("ar_no_wb_after_release", 32'(bus.wb_valid), 32'd0);
    end

    // Randomized traffic with occasional flushes and reset pulses
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_id($urandom_range(0, 3) != 0, wb_t'($urandom), m_t'($urandom), ex_t'($urandom),
             reg_t'($urandom_range(0, 3)), reg_t'($urandom_range(0, 3)),
             reg_t'($urandom_range(0, 3)));
      bus.flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        #1 rst_n = 1'b1;
      end
      step();
    end
    bus.flush = 1'b0;
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ctrl_pipe_regs

`default_nettype wire

// File: doc/ctrl_pipe_regs.md
CTRL_PIPE_REGS -- requirements
Module: ctrl_pipe_regs

Interface
REQ-001 Parameter WB_W, 2, width of the write-back control field.
REQ-002 Parameter M_W, 3, width of the memory control field.
REQ-003 Parameter EX_W, 8, width of the execute control field.
REQ-004 Parameter REG_W, 5, width of a register index.
REQ-005 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port id_valid  in  1  the decode stage holds a real instruction.
REQ-008 Port id_wb / id_m / id_ex  in  WB_W / M_W / EX_W  decoded control fields from the control unit.
REQ-009 Port id_rs, id_rt, id_dst  in  REG_W each  source registers and destination register of the decoding instruction.
REQ-010 Port flush  in  1  a branch is taken in MEM; kill the younger instructions.
REQ-011 Port ex_valid/ex_wb/ex_m/ex_ex/ex_dst  out  1/WB_W/M_W/EX_W/REG_W  contents of the ID/EX register.
REQ-012 Port mem_valid/mem_wb/mem_m/mem_dst  out  1/WB_W/M_W/REG_W  contents of the EX/MEM register.
REQ-013 Port wb_valid/wb_wb/wb_dst  out  1/WB_W/REG_W  contents of the MEM/WB register.
REQ-014 Port stall_out  out  1  combinational; when high, upstream holds PC and IF/ID.

Function
REQ-015 Field meanings SHALL be fixed as follows: wb[1]=RegWrite, wb[0]=MemToReg; m[2]=Branch, m[1]=MemRead, m[0]=MemWrite.
REQ-016 A bubble SHALL be valid=0 with every control field and dst at zero.
REQ-017 Each edge with no flush and no stall SHALL move the stages as follows: ID/EX<=id_* (valid=id_valid), EX/MEM<=ID/EX minus the EX field, MEM/WB<=EX/MEM minus the M field.
REQ-018 Latency SHALL be one cycle per stage: an id_* value appears on ex_* after 1 edge, on mem_* after 2 edges and on wb_* after 3 edges.
REQ-019 When stall_out=1, ID/EX SHALL load a bubble, and EX/MEM and MEM/WB SHALL still advance.
REQ-020 When flush=1, ID/EX and EX/MEM SHALL both load bubbles, and MEM/WB SHALL still load the current EX/MEM.
REQ-021 flush SHALL take priority over stall_out, and stall_out SHALL be forced to 0 while flush=1.
REQ-022 When id_valid=0, ID/EX SHALL load a bubble regardless of the values on id_*.
REQ-023 The downstream registers SHALL never stall: there is no back-pressure beyond ID.

Reset
REQ-024 While rst_n=0, every stage register SHALL be a bubble immediately, without waiting for clk, and stall_out SHALL be 0.
REQ-025 On the first rising edge after rst_n deasserts, the block SHALL resume normal advance per REQ-017.
REQ-026 If reset is asserted mid-operation, all in-flight instructions SHALL be discarded and none SHALL be completed after reset.

Configuration
REQ-027 Macro LOAD_USE_STALL_EN defined: stall_out=1 exactly when all of the following hold: ex_valid, ex_m[1], id_valid, ex_dst!=0, and ex_dst equals id_rs or id_rt.
REQ-028 Macro LOAD_USE_STALL_EN undefined: stall_out SHALL be constant 0 and no comparator logic SHALL be generated.

Structure
REQ-029 The shared package ctrl_pkg SHALL hold: the field widths, the field bit-position constants from REQ-015, the bubble constants, and the WB/M/EX bundle typedefs.
REQ-030 One sub-module, ctrl_stage_reg, SHALL be used: a parameterised register with async active-low reset, load and clear-to-bubble inputs, instantiated three times.
REQ-031 The hazard comparator SHALL be inline logic in ctrl_pipe_regs and not a separate module.

Verification
REQ-032 Reset release with id_valid=1, id_wb=2'b10, id_ex=8'h82, id_dst=3 -> ex_* after edge 1, mem_wb=2'b10 after edge 2, wb_wb=2'b10 and wb_dst=3 after edge 3.
REQ-033 Load (wb=11, m=010, dst=5) followed by id_rs=5 with LOAD_USE_STALL_EN defined -> stall_out=1 for one cycle, ex_valid=0 the next cycle, load reaches mem_m=010; without the macro -> stall_out stays 0.
REQ-034 Load with dst=0 followed by id_rt=0 -> stall_out=0.
REQ-035 flush=1 while ID/EX and EX/MEM are valid -> next edge: ex_valid=0, mem_valid=0, and wb_* equals the prior mem_*.
REQ-036 flush=1 and the hazard condition true in the same cycle -> stall_out=0, and bubbles are loaded per REQ-020.
REQ-037 rst_n pulsed low between clock edges with three valid stages -> all valid outputs go to 0 immediately, and no wb_valid pulse follows reset release.
